instruction_fetch_unit: RTL and testbench

Sequences the byte-addressed, combinational-read instruction memory: owns the program counter, drives the memory address, and registers each fetched 32-bit word into a one-entry output stage with a valid/ready handshake toward decode. It accepts PC redirects (taken branches, CBZ) from execute, flushes the wrong-path word, and supports start/halt control. It sits between the instruction memory and the decode stage.

---
 rtl/instruction_fetch_unit_pkg.sv | 15 +
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit_out_reg.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 tb/tb_instruction_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM state encoding, instruction size and default memory/reset parameters.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam int unsigned INST_BYTES         = 4;
  localparam int unsigned DEFAULT_IMEM_BYTES = 256;
  localparam logic [63:0] DEFAULT_RESET_PC   = 64'd0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory port, decode handshake and execute redirect.
// master = fetch unit, slave = surrounding memory/decode/execute.
interface instruction_fetch_unit_if #(
  parameter int unsigned PC_W = 64
);

  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic [31:0]     inst_out;
  logic [PC_W-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;

  modport master (
    output imem_addr, inst_out, inst_pc, inst_valid,
    input  imem_data, inst_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, inst_out, inst_pc, inst_valid,
    output imem_data, inst_ready, redirect_valid, redirect_target
  );

endinterface

// File: rtl/instruction_fetch_unit_out_reg.sv
// fetch_out_reg: one-entry valid/ready pipeline register with flush; 1-cycle latency.
// Holds its word while out_rdy is low; accepts a new word when empty or draining.
module fetch_out_reg #(
  parameter int unsigned DW = 96
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat
);

  assign in_rdy = !out_vld || out_rdy;

  // Flush only drops the valid bit; stale data is harmless once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (in_vld && in_rdy) begin
      out_vld <= 1'b1;
      out_dat <= in_dat;
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, start/halt FSM, redirect flush; 1-cycle fetch latency, holds under backpressure.
// Define FETCH_ADDR_CHECK_EN to enable the fetch/redirect address fault check.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     IMEM_BYTES = DEFAULT_IMEM_BYTES,
  parameter int unsigned     PC_W       = 64,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      halt_req,
  output logic                      busy,
  output logic                      fault,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_FAULT = FAULT;

  logic [1:0]       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  redirect_pc;
  logic             redirect;
  logic             out_in_rdy;
  logic             cap_cond;
  logic             capture;
  logic             flush;
  logic             redir_fault;
  logic             fetch_fault;
  logic [31+PC_W:0] out_dat;

  assign redirect    = bus.redirect_valid && (state_q != ST_FAULT);
  assign redirect_pc = {bus.redirect_target[PC_W-1:2], 2'b00};
  assign cap_cond    = (state_q == ST_FETCH) && out_in_rdy && !redirect && !halt_req;

`ifdef FETCH_ADDR_CHECK_EN
  // Widened by one bit so an address near the top of the PC space cannot wrap past the limit.
  logic [PC_W:0] last_byte;
  assign last_byte   = {1'b0, pc_q} + (PC_W+1)'(INST_BYTES - 1);
  assign redir_fault = redirect && (bus.redirect_target[1:0] != 2'b00);
  assign fetch_fault = cap_cond && (last_byte >= (PC_W+1)'(IMEM_BYTES));
  assign fault       = (state_q == ST_FAULT);
`else
  assign redir_fault = 1'b0;
  assign fetch_fault = 1'b0;
  assign fault       = 1'b0;
`endif

  assign capture       = cap_cond && !fetch_fault;
  assign flush         = redirect || fetch_fault;
  assign busy          = (state_q == ST_FETCH);
  assign bus.imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else if (redir_fault) begin
      state_q <= ST_FAULT;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !halt_req) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (halt_req)         state_q <= ST_IDLE;
          else if (fetch_fault) state_q <= ST_FAULT;
          else if (capture)     pc_q    <= pc_q + PC_W'(INST_BYTES);
        end
        default: ;
      endcase
    end
  end

  fetch_out_reg #(
    .DW (32 + PC_W)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_vld  (capture),
    .in_rdy  (out_in_rdy),
    .in_dat  ({bus.imem_data, pc_q}),
    .out_vld (bus.inst_valid),
    .out_rdy (bus.inst_ready),
    .out_dat (out_dat)
  );

  assign {bus.inst_out, bus.inst_pc} = out_dat;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: architectural fetch model checked every cycle plus directed literal checks.
module tb_instruction_fetch_unit;

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic clk;
  logic reset;
  logic start;
  logic halt_req;
  logic busy;
  logic fault;

  instruction_fetch_unit_if #(.PC_W(64)) bus ();

  instruction_fetch_unit #(
    .IMEM_BYTES (256),
    .PC_W       (64),
    .RESET_PC   (64'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .halt_req (halt_req),
    .busy     (busy),
    .fault    (fault),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program image: a few fixed words, address-tagged filler elsewhere, a marker past the end.
  function automatic logic [31:0] img(input logic [63:0] a);
    if (a >= 64'd256) return 32'hDEAD_BEEF;
    case (a)
      64'd0:   return 32'hF840_03E0;
      64'd4:   return 32'hF840_83E1;
      64'd8:   return 32'hF841_03E2;
      64'd52:  return 32'h8B01_03E2;
      64'd56:  return 32'hCB02_0085;
      default: return 32'hA000_0000 | a[31:0];
    endcase
  endfunction

  always_comb bus.imem_data = img(bus.imem_addr);

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: running flag, next PC, one output slot, sticky fault.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst;
  bit          m_run, m_vld, m_flt;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 64'd0; m_ipc = 64'd0; m_inst = 32'd0;
      m_run = 1'b0; m_vld = 1'b0; m_flt = 1'b0;
    end else if (bus.redirect_valid && !m_flt) begin
      if (CHECK && bus.redirect_target[1:0] != 2'b00) begin
        m_flt = 1'b1;
        m_run = 1'b0;
      end else begin
        m_pc = bus.redirect_target & ~64'd3;
      end
      m_vld = 1'b0;
    end else if (!m_flt) begin
      if (m_run && !halt_req && (!m_vld || bus.inst_ready)) begin
        if (CHECK && ({1'b0, m_pc} + 65'd3 >= 65'd256)) begin
          m_flt = 1'b1; m_run = 1'b0; m_vld = 1'b0;
        end else begin
          m_vld = 1'b1; m_ipc = m_pc; m_inst = img(m_pc); m_pc = m_pc + 64'd4;
        end
      end else begin
        if (m_vld && bus.inst_ready) m_vld = 1'b0;
        if (!m_run && start && !halt_req) m_run = 1'b1;
        else if (m_run && halt_req)       m_run = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",     {63'd0, bus.inst_valid}, {63'd0, m_vld});
      chk("imem_addr", bus.imem_addr,           m_pc);
      chk("busy",      {63'd0, busy},           {63'd0, m_run});
      chk("fault",     {63'd0, fault},          {63'd0, m_flt});
      chk("inst_pc",   bus.inst_pc,             m_ipc);
      chk("inst_out",  {32'd0, bus.inst_out},   {32'd0, m_inst});
    end
  end

  // Log of completed handshakes (PC of each delivered word).
  logic [63:0] acc_q[$];
  always @(posedge clk) begin
    if (!reset && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) acc_q.push_back(bus.inst_pc);
  end

  function automatic int n_acc(input logic [63:0] pc);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i] == pc) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [63:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    tick();
    bus.redirect_valid  = 1'b0;
  endtask

  task automatic out_is(input string nm, input logic [63:0] pc, input logic [31:0] w);
    chk({nm, "_v"},   {63'd0, bus.inst_valid}, 64'd1);
    chk({nm, "_pc"},  bus.inst_pc,             pc);
    chk({nm, "_dat"}, {32'd0, bus.inst_out},   {32'd0, w});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 64'd0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("rst_addr",  bus.imem_addr,           64'd0);
    chk("rst_busy",  {63'd0, busy},           64'd0);
    chk("rst_fault", {63'd0, fault},          64'd0);
    chk("rst_out",   {32'd0, bus.inst_out},   64'd0);
    reset = 1'b0;

    // Streaming
    start = 1'b1; bus.inst_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",  {63'd0, busy},           64'd1);
    chk("start_valid", {63'd0, bus.inst_valid}, 64'd0);
    tick(); out_is("s0", 64'd0, 32'hF840_03E0);
    tick(); out_is("s4", 64'd4, 32'hF840_83E1);

    // Backpressure
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      out_is("bp", 64'd4, 32'hF840_83E1);
      chk("bp_addr", bus.imem_addr, 64'd8);
    end
    bus.inst_ready = 1'b1;
    tick(); out_is("s8", 64'd8, 32'hF841_03E2);
    tick(); out_is("s12", 64'd12, 32'hA000_000C);

    // Halt and resume
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_busy",  {63'd0, busy},           64'd0);
    chk("halt_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("halt_addr",  bus.imem_addr,           64'd16);
    tick();
    chk("idle_addr", bus.imem_addr, 64'd16);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); out_is("resume16", 64'd16, 32'hA000_0010);

    // Redirect while a word is held
    bus.inst_ready = 1'b0;
    tick();
    redir(64'd52);
    chk("rd_bubble", {63'd0, bus.inst_valid}, 64'd0);
    chk("rd_addr",   bus.imem_addr,           64'd52);
    bus.inst_ready = 1'b1;
    tick(); out_is("rd52", 64'd52, 32'h8B01_03E2);
    tick(); out_is("rd56", 64'd56, 32'hCB02_0085);

    // Redirect together with inst_ready
    redir(64'd0);
    chk("rr_valid", {63'd0, bus.inst_valid}, 64'd0);
    tick(); out_is("rr0", 64'd0, 32'hF840_03E0);
    chk("once56",  n_acc(64'd56), 64'd1);
    chk("once52",  n_acc(64'd52), 64'd1);
    chk("drop16",  n_acc(64'd16), 64'd0);

`ifdef FETCH_ADDR_CHECK_EN
    redir(64'd252);
    chk("f252_addr", bus.imem_addr, 64'd252);
    tick(); out_is("f252", 64'd252, 32'hA000_00FC);
    tick();
    chk("oob_fault", {63'd0, fault},          64'd1);
    chk("oob_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("oob_busy",  {63'd0, busy},           64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("clr_fault", {63'd0, fault}, 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    redir(64'd254);
    chk("m254_fault", {63'd0, fault},          64'd1);
    chk("m254_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("m254_addr",  bus.imem_addr,           64'd4);
    redir(64'd0);
    chk("sticky_addr",  bus.imem_addr,  64'd4);
    start = 1'b1; tick(); start = 1'b0;
    chk("sticky_fault", {63'd0, fault}, 64'd1);
    chk("sticky_busy",  {63'd0, busy},  64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    redir(64'd53);
    chk("m53_fault", {63'd0, fault}, 64'd1);
`else
    redir(64'd53);
    chk("al53_addr", bus.imem_addr, 64'd52);
    tick(); out_is("al52", 64'd52, 32'h8B01_03E2);
    redir(64'd252);
    tick(); out_is("e252", 64'd252, 32'hA000_00FC);
    tick(); out_is("e256", 64'd256, 32'hDEAD_BEEF);
    chk("nochk_fault", {63'd0, fault}, 64'd0);
    redir(64'hFFFF_FFFF_FFFF_FFFD);
    tick(); out_is("wtop", 64'hFFFF_FFFF_FFFF_FFFC, 32'hDEAD_BEEF);
    tick(); out_is("wrap", 64'd0, 32'hF840_03E0);
`endif

    // Reset during backpressure
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; bus.inst_ready = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    bus.inst_ready = 1'b0;
    tick(); out_is("pre_rst", 64'd4, 32'hF840_83E1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_valid", {63'd0, bus.inst_valid}, 64'd0);
    chk("mr_pc",    bus.inst_pc,             64'd0);
    chk("mr_out",   {32'd0, bus.inst_out},   64'd0);
    chk("mr_addr",  bus.imem_addr,           64'd0);
    chk("mr_busy",  {63'd0, busy},           64'd0);

    // start and halt_req together in IDLE
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    chk("sh_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("sh_busy2", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
